// File: rtl/digit_qualify_ctrl.sv
// Digit qualification controller for the DTMF receive path: accepts a digit after
// STABLE_CNT identical tone frames and re-arms only after GAP_CNT silent frames.
module digit_qualify_ctrl #(
  parameter int STABLE_CNT = 3,
  parameter int GAP_CNT    = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_valid,
  input  logic       det_tone,
  input  logic [7:0] det_digit,
  output logic [7:0] digit_out,
  output logic       flag_out,
  output logic       tone_active
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   STABLE_LIM = (CNT_W+1)'(STABLE_CNT);
  localparam logic [CNT_W:0]   GAP_LIM    = (CNT_W+1)'(GAP_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_digit, w_digit_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_tone_active, w_tone_nxt;
  logic [CNT_W:0]   w_cnt_inc;

  // Widened increment so the limit compare cannot alias on overflow.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

  // State, candidate, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cand        <= 8'hff;
      r_cnt         <= CNT_ZERO;
      r_digit       <= 8'hff;
      r_flag        <= 1'b1;
      r_tone_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cand        <= w_cand_nxt;
      r_cnt         <= w_cnt_nxt;
      r_digit       <= w_digit_nxt;
      r_flag        <= w_flag_nxt;
      r_tone_active <= w_tone_nxt;
    end
  end

  // Next-state, counter and report decisions; everything holds unless a frame is strobed.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_flag_nxt  = r_flag;
    if (det_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (det_tone) begin
            w_cand_nxt  = det_digit;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ST_QUAL;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_QUAL: begin
          if (!det_tone) begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_IDLE;
          end else if (det_digit != r_cand) begin
            w_cand_nxt = det_digit;
            w_cnt_nxt  = CNT_ONE;
          end else if (w_cnt_inc == STABLE_LIM) begin
            w_digit_nxt = r_cand;
            w_flag_nxt  = ~r_flag;
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          end
        end
        ST_HOLD: begin
          if (det_tone) begin
            w_state_nxt = ST_HOLD;
          end else if (GAP_LIM == (CNT_W+1)'(1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ST_GAP;
          end
        end
        ST_GAP: begin
          if (det_tone) begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_HOLD;
          end else if (w_cnt_inc == GAP_LIM) begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_tone_nxt  = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_GAP);
  assign digit_out   = r_digit;
  assign flag_out    = r_flag;
  assign tone_active = r_tone_active;

endmodule

// File: tb/tb_digit_qualify_ctrl.sv
// Self-checking bench: directed scenarios plus random frames against a run-length reference model,
// on a default instance and a GAP_CNT=1 instance sharing the same stimulus.
module tb_digit_qualify_ctrl;

  localparam int STABLE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       det_valid = 1'b0;
  logic       det_tone = 1'b0;
  logic [7:0] det_digit = 8'h00;
  logic [7:0] digit_out [2];
  logic       flag_out [2];
  logic       tone_active [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: armed = waiting for a digit, run_* = current identical-tone run,
  // sil = consecutive silent frames since the last report.
  bit         m_armed [2];
  logic [7:0] m_run_digit [2];
  int         m_run_len [2];
  int         m_sil [2];
  logic [7:0] m_digit [2];
  logic       m_flag [2];
  int         gap_of [2] = '{2, 1};

  always #5 clk = ~clk;

  digit_qualify_ctrl #(.STABLE_CNT(3), .GAP_CNT(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .det_valid(det_valid), .det_tone(det_tone), .det_digit(det_digit),
    .digit_out(digit_out[0]), .flag_out(flag_out[0]), .tone_active(tone_active[0]));

  digit_qualify_ctrl #(.STABLE_CNT(3), .GAP_CNT(1), .CNT_W(4)) u_dut_g1 (
    .clk(clk), .reset(reset), .det_valid(det_valid), .det_tone(det_tone), .det_digit(det_digit),
    .digit_out(digit_out[1]), .flag_out(flag_out[1]), .tone_active(tone_active[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_armed[k] = 1'b1; m_run_digit[k] = 8'hff; m_run_len[k] = 0;
      m_sil[k] = 0; m_digit[k] = 8'hff; m_flag[k] = 1'b1;
    end
  endtask

  task automatic model_step(input int k);
    if (det_valid) begin
      if (m_armed[k]) begin
        if (det_tone) begin
          if (m_run_len[k] > 0 && det_digit == m_run_digit[k]) m_run_len[k]++;
          else begin m_run_digit[k] = det_digit; m_run_len[k] = 1; end
          if (m_run_len[k] == STABLE) begin
            m_digit[k] = m_run_digit[k]; m_flag[k] = ~m_flag[k];
            m_armed[k] = 1'b0; m_sil[k] = 0;
          end
        end else begin
          m_run_len[k] = 0;
        end
      end else if (det_tone) begin
        m_sil[k] = 0;
      end else begin
        m_sil[k]++;
        if (m_sil[k] >= gap_of[k]) begin m_armed[k] = 1'b1; m_run_len[k] = 0; end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_digit%0d", ph, k), {24'h0, digit_out[k]}, {24'h0, m_digit[k]});
      chk($sformatf("%s_flag%0d", ph, k), {31'h0, flag_out[k]}, {31'h0, m_flag[k]});
      chk($sformatf("%s_tact%0d", ph, k), {31'h0, tone_active[k]}, {31'h0, ~m_armed[k]});
    end
  endtask

  task automatic frame(input logic v, input logic t, input logic [7:0] d, input string ph);
    @(negedge clk);
    det_valid = v; det_tone = t; det_digit = d;
    @(posedge clk);
    model_step(0); model_step(1);
    #1 check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    @(negedge clk);
    det_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_rdig%0d", ph, k), {24'h0, digit_out[k]}, 32'h0000_00ff);
      chk($sformatf("%s_rflg%0d", ph, k), {31'h0, flag_out[k]}, 32'h1);
      chk($sformatf("%s_rtac%0d", ph, k), {31'h0, tone_active[k]}, 32'h0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  logic [7:0] pool [4] = '{8'h31, 8'h32, 8'h35, 8'h39};

  initial begin
    model_reset();
    #13 reset = 1'b1;
    frame(1'b0, 1'b0, 8'h00, "init");
    do_reset("rst0");

    // Basic accept and hold
    repeat (3) frame(1'b1, 1'b1, 8'h35, "acc");
    chk("acc_digit", {24'h0, digit_out[0]}, 32'h35);
    chk("acc_flag", {31'h0, flag_out[0]}, 32'h0);
    chk("acc_tact", {31'h0, tone_active[0]}, 32'h1);
    frame(1'b1, 1'b1, 8'h35, "hold");
    chk("hold_flag", {31'h0, flag_out[0]}, 32'h0);

    // Broken gap, completed gap, second report
    frame(1'b1, 1'b0, 8'h00, "gap1");
    frame(1'b1, 1'b1, 8'h35, "gapbrk");
    chk("gapbrk_flag", {31'h0, flag_out[0]}, 32'h0);
    chk("gapbrk_tact", {31'h0, tone_active[0]}, 32'h1);
    repeat (2) frame(1'b1, 1'b0, 8'h00, "gap2");
    chk("gap_done_tact", {31'h0, tone_active[0]}, 32'h0);
    repeat (3) frame(1'b1, 1'b1, 8'h35, "acc2");
    chk("acc2_flag", {31'h0, flag_out[0]}, 32'h1);

    // Strobe gating
    repeat (10) frame(1'b0, 1'b1, 8'h39, "gate");
    chk("gate_digit", {24'h0, digit_out[0]}, 32'h35);

    // Candidate change
    repeat (2) frame(1'b1, 1'b0, 8'h00, "sil");
    frame(1'b1, 1'b1, 8'h31, "cc"); frame(1'b1, 1'b1, 8'h31, "cc");
    frame(1'b1, 1'b1, 8'h32, "cc"); frame(1'b1, 1'b1, 8'h32, "cc");
    chk("cc_noflag", {31'h0, flag_out[0]}, 32'h1);
    frame(1'b1, 1'b1, 8'h32, "cc");
    chk("cc_digit", {24'h0, digit_out[0]}, 32'h32);
    chk("cc_flag", {31'h0, flag_out[0]}, 32'h0);

    // Reset during qualification
    repeat (2) frame(1'b1, 1'b0, 8'h00, "sil");
    repeat (2) frame(1'b1, 1'b1, 8'h35, "rq");
    do_reset("rstq");
    frame(1'b1, 1'b1, 8'h35, "rq1");
    chk("rq1_flag", {31'h0, flag_out[0]}, 32'h1);
    frame(1'b1, 1'b1, 8'h35, "rq2");
    chk("rq2_flag", {31'h0, flag_out[0]}, 32'h1);
    frame(1'b1, 1'b1, 8'h35, "rq3");
    chk("rq3_flag", {31'h0, flag_out[0]}, 32'h0);
    chk("rq3_digit", {24'h0, digit_out[0]}, 32'h35);

    // GAP_CNT=1 corner on the second instance
    frame(1'b1, 1'b0, 8'h00, "g1");
    chk("g1_tact", {31'h0, tone_active[1]}, 32'h0);

    // Random frames
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rrst");
      else frame(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 pool[$urandom_range(0, 3)], "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
